tff_counter_ctrl: RTL and testbench

- Controller that sequences a bank of WIDTH toggle flip-flops so they behave as a loadable up/down counter with a terminal-count stop.
- Each cycle it computes the per-bit T (toggle) vector from the current flop state, the direction and the load value, and drives it into the flop bank.
- Sits between a host control interface (start/stop/load) and the toggle-flop datapath. The bank is instantiated internally as one bit-cell per bit.

---
 rtl/tff_ctrl_pkg.sv | 41 ++++
 rtl/tff_counter_ctrl_bit_cell.sv | 25 ++
 rtl/tff_counter_ctrl.sv | 157 +++++++++++++++
 tb/tb_tff_counter_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the toggle-flop counter controller: FSM state
// encoding, default counter width and the up/down toggle-vector helper.
// Optional feature macro used by the controller: TFF_CTRL_STEP_EN.
package tff_ctrl_pkg;

  // Default number of toggle flops in the bank.
  localparam int DEFAULT_WIDTH = 4;

  // Widest bank the controller supports; the helper below works at this
  // width and callers truncate to their own WIDTH.
  localparam int MAX_WIDTH = 16;

  // Width of the FSM state encoding.
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Toggle vector that advances a binary count by one step.
  // Bit 0 always toggles; bit i toggles when every lower bit is 1 (up)
  // or every lower bit is 0 (down). Natural modulo wrap falls out of this.
  function automatic logic [MAX_WIDTH-1:0] calc_toggle(
    input logic [MAX_WIDTH-1:0] q,
    input logic                 dir
  );
    logic [MAX_WIDTH-1:0] t;
    logic                 carry;
    t     = '0;
    carry = 1'b1;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      t[i]  = carry;
      carry = carry & (dir ? q[i] : ~q[i]);
    end
    return t;
  endfunction

endpackage : tff_ctrl_pkg

// File: rtl/tff_counter_ctrl_bit_cell.sv
// Single toggle flip-flop: inverts its state on a rising clock edge when
// t is high, clears asynchronously on rst.
module tff_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;

  // Toggle storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: flops are written with <= so every cell samples the toggle
    // vector computed from the pre-edge state, never a partially updated one.
    if (rst) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule : tff_bit_cell

// File: rtl/tff_counter_ctrl.sv
// Toggle-flop counter controller. Drives a bank of WIDTH toggle flops so
// they act as a loadable up/down counter that can halt or wrap at a
// terminal value. The toggle vector is combinational from the current
// state, flop contents and control inputs; the bank is built from
// tff_bit_cell instances.
// Optional feature macro: TFF_CTRL_STEP_EN (adds a single-step input that
// counts once from IDLE/DONE without changing state).
module tff_counter_ctrl
  import tff_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] term_value,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
`ifdef TFF_CTRL_STEP_EN
  input  logic             step,
`endif
  output logic             load_ready,
  output logic [WIDTH-1:0] toggle_vec,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             tc_pulse
);

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_load_val;
  logic             r_tc;

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_toggle;
  logic [WIDTH-1:0] w_count_toggle;
  logic             w_capture;
  logic             w_at_term;
  logic             w_step;

  // One-step count toggles for the current direction.
  assign w_count_toggle = WIDTH'(calc_toggle(MAX_WIDTH'(w_q), dir));
  assign w_at_term      = (w_q == term_value);

`ifdef TFF_CTRL_STEP_EN
  assign w_step = step;
`else
  assign w_step = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Load capture register; holds the target value for the LOAD cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this holding register is cleared on reset so a load accepted
    // before an aborting reset can never reappear afterwards.
    if (rst) begin
      r_load_val <= '0;
    end else if (w_capture) begin
      r_load_val <= load_value;
    end
  end

  // Terminal-count pulse: high for the cycle after RUN sees q == term_value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc <= 1'b0;
    end else begin
      r_tc <= (r_state == ST_RUN) && !stop && w_at_term;
    end
  end

  // Next-state and toggle-vector decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_next_state = r_state;
    w_toggle     = '0;
    w_capture    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (load_valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_LOAD;
        end else if (start) begin
          w_next_state = ST_RUN;
        end else if (w_step) begin
          w_toggle = w_count_toggle;
        end
      end

      ST_RUN: begin
        if (stop) begin
          w_next_state = ST_IDLE;
        end else if (w_at_term && !wrap_en) begin
          w_next_state = ST_DONE;
        end else begin
          w_toggle = w_count_toggle;
        end
      end

      ST_LOAD: begin
        // Flip exactly the bits that differ from the captured target.
        w_toggle     = w_q ^ r_load_val;
        w_next_state = ST_IDLE;
      end

      ST_DONE: begin
        if (load_valid) begin
          w_capture    = 1'b1;
          w_next_state = ST_LOAD;
        end else if (start) begin
          w_next_state = ST_RUN;
        end else begin
          if (stop) begin
            w_next_state = ST_IDLE;
          end
          if (w_step) begin
            w_toggle = w_count_toggle;
          end
        end
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Toggle flop bank, one cell per counter bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_bit_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (w_toggle[i]),
      .q   (w_q[i])
    );
  end

  assign q          = w_q;
  assign toggle_vec = w_toggle;
  assign tc_pulse   = r_tc;
  assign busy       = (r_state == ST_RUN) || (r_state == ST_LOAD);
  assign load_ready = (r_state == ST_IDLE) || (r_state == ST_DONE);

endmodule : tff_counter_ctrl

// File: tb/tb_tff_counter_ctrl.sv
// Self-checking bench for tff_counter_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// counter written in plain arithmetic.
module tb_tff_counter_ctrl;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         start;
  logic         stop;
  logic         dir;
  logic         wrap_en;
  logic [W-1:0] term_value;
  logic         load_valid;
  logic [W-1:0] load_value;
  logic         step;
  logic         load_ready;
  logic [W-1:0] toggle_vec;
  logic [W-1:0] q;
  logic         busy;
  logic         tc_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  int    m_q;
  int    m_ld;
  bit    m_tc;
  string m_mode;

  tff_counter_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .dir        (dir),
    .wrap_en    (wrap_en),
    .term_value (term_value),
    .load_valid (load_valid),
    .load_value (load_value),
`ifdef TFF_CTRL_STEP_EN
    .step       (step),
`endif
    .load_ready (load_ready),
    .toggle_vec (toggle_vec),
    .q          (q),
    .busy       (busy),
    .tc_pulse   (tc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_q    = 0;
    m_ld   = 0;
    m_tc   = 0;
    m_mode = "idle";
  endtask

  function automatic int count_one(input int v, input logic d);
    return d ? (v + 1) % MOD : (v + MOD - 1) % MOD;
  endfunction

  // Called just after a falling edge with inputs already driven: checks the
  // outputs of the current cycle, then advances the model over the next
  // rising edge and returns at the following falling edge.
  task automatic cycle();
    int    nq;
    int    nld;
    bit    ntc;
    string nmode;
    nq    = m_q;
    nld   = m_ld;
    ntc   = 0;
    nmode = m_mode;
    if (m_mode == "idle" || m_mode == "done") begin
      if (load_valid) begin
        nmode = "load";
        nld   = int'(load_value);
      end else if (start) begin
        nmode = "run";
      end else if (stop && m_mode == "done") begin
        nmode = "idle";
      end
    end else if (m_mode == "run") begin
      if (stop) begin
        nmode = "idle";
      end else if (m_q == int'(term_value)) begin
        ntc = 1;
        if (wrap_en) nq = count_one(m_q, dir);
        else         nmode = "done";
      end else begin
        nq = count_one(m_q, dir);
      end
    end else begin
      nq    = m_ld;
      nmode = "idle";
    end

    #1;
    chk("q", 32'(q), 32'(m_q));
    chk("tc_pulse", 32'(tc_pulse), 32'(m_tc));
    chk("busy", 32'(busy), 32'(m_mode == "run" || m_mode == "load"));
    chk("load_ready", 32'(load_ready), 32'(m_mode == "idle" || m_mode == "done"));
    chk("toggle_vec", 32'(toggle_vec), 32'(m_q ^ nq));

    @(posedge clk);
    m_q    = nq;
    m_ld   = nld;
    m_tc   = ntc;
    m_mode = nmode;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    stop       = 1'b0;
    load_valid = 1'b0;
    step       = 1'b0;
  endtask

  // Load a value from IDLE: handshake cycle, LOAD cycle.
  task automatic do_load(input logic [W-1:0] v);
    load_valid = 1'b1;
    load_value = v;
    cycle();
    load_valid = 1'b0;
    cycle();
  endtask

  initial begin
    rst        = 1'b1;
    idle_inputs();
    dir        = 1'b1;
    wrap_en    = 1'b0;
    term_value = '0;
    load_value = '0;
    model_reset();

    // Reset held for two edges, released away from the edge.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // Load 4'hA from IDLE.
    term_value = 4'h3;
    do_load(4'hA);
    cycle();

    // Count up from 0 to terminal 3 and halt.
    do_load(4'h0);
    dir     = 1'b1;
    wrap_en = 1'b0;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
    repeat (7) cycle();

    // Restart at terminal: immediate re-termination.
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // Wrap upward through F with terminal F.
    term_value = 4'hF;
    wrap_en    = 1'b1;
    do_load(4'hE);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (4) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // Wrap downward through 0.
    dir = 1'b0;
    do_load(4'h1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // stop and start together in RUN at q=5.
    dir        = 1'b1;
    term_value = 4'h0;
    wrap_en    = 1'b0;
    do_load(4'h5);
    start = 1'b1;
    cycle();
    stop  = 1'b1;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    cycle();

    // load_valid and start together in IDLE: load wins.
    load_valid = 1'b1;
    start      = 1'b1;
    load_value = 4'h9;
    cycle();
    load_valid = 1'b0;
    start      = 1'b0;
    repeat (2) cycle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (n % 32 == 0) term_value = W'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      stop       = ($urandom_range(0, 11) == 0);
      load_valid = ($urandom_range(0, 9) == 0);
      load_value = W'($urandom);
      dir        = 1'($urandom);
      wrap_en    = 1'($urandom);
      cycle();
    end
    idle_inputs();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    cycle();

    // Asynchronous reset while running at q=7.
    dir        = 1'b1;
    wrap_en    = 1'b0;
    term_value = 4'h0;
    do_load(4'h7);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("run_before_reset", 32'(busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_q", 32'(q), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_load_ready", 32'(load_ready), 32'(1));
    chk("async_rst_tc", 32'(tc_pulse), 32'(0));
    chk("async_rst_toggle", 32'(toggle_vec), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tff_counter_ctrl
